// File: rtl/asmd_mult_sequencer.sv
// asmd_mult_sequencer
// Operand sequencer that sits in front of an asmd_multiplier. Operand pairs
// are buffered in a small FIFO and launched one at a time through the
// multiplier's start/ready handshake. Each product is captured into a result
// register that is offered to the consumer with a valid/ack handshake.
//
// Optional feature: define ASMD_SEQ_COUNT_EN to add the 16-bit done_count
// output, which counts accepted results and wraps from 0xFFFF to 0x0000.

module asmd_mult_sequencer #(
    parameter int word_length = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [word_length-1:0]     in_a,
    input  logic [word_length-1:0]     in_b,
    output logic [word_length-1:0]     mul_word0,
    output logic [word_length-1:0]     mul_word1,
    output logic                       mul_start,
    input  logic                       mul_ready,
    input  logic [2*word_length-1:0]   mul_product,
    output logic                       res_valid,
    output logic [2*word_length-1:0]   res_product,
`ifdef ASMD_SEQ_COUNT_EN
    output logic [15:0]                done_count,
`endif
    input  logic                       res_ack
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [word_length-1:0] mem_a_r [FIFO_DEPTH];
    logic [word_length-1:0] mem_b_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_next_s;
    logic                   in_ready_r;
    logic                   push_s;
    logic                   pop_s;

    // Sequencer state and registered outputs
    state_t                   state_r;
    logic [word_length-1:0]   mul_word0_r;
    logic [word_length-1:0]   mul_word1_r;
    logic                     mul_start_r;
    logic                     res_valid_r;
    logic [2*word_length-1:0] res_product_r;

    // Push only when the registered ready flag is high; pop only when the
    // sequencer is idle, data is queued, the multiplier is free and no
    // result is still waiting for the consumer.
    always_comb begin
        push_s = in_valid && in_ready_r;
        pop_s  = (state_r == ST_IDLE) && (count_r != {CNT_W{1'b0}}) &&
                 mul_ready && !res_valid_r;
    end

    // Next occupancy: push+pop together leaves the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO data write; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r] <= in_a;
            mem_b_r[wr_ptr_r] <= in_b;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    // in_ready is derived from the next count so that a pop never opens a
    // combinational path to in_ready; a slot freed while full is offered
    // only on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // Launch/complete sequencer with registered handshake outputs.
    // Operand words stay stable from launch until the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            mul_word0_r   <= {word_length{1'b0}};
            mul_word1_r   <= {word_length{1'b0}};
            mul_start_r   <= 1'b0;
            res_valid_r   <= 1'b0;
            res_product_r <= {(2*word_length){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        mul_word0_r <= mem_a_r[rd_ptr_r];
                        mul_word1_r <= mem_b_r[rd_ptr_r];
                        mul_start_r <= 1'b1;
                        state_r     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    mul_start_r <= 1'b0;
                    state_r     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!mul_ready) begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (mul_ready) begin
                        res_product_r <= mul_product;
                        res_valid_r   <= 1'b1;
                        state_r       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_ack) begin
                        res_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    mul_start_r <= 1'b0;
                    res_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ASMD_SEQ_COUNT_EN
    logic [15:0] done_count_r;

    // Count accepted results; natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_count_r <= 16'd0;
        end else if (res_valid_r && res_ack) begin
            done_count_r <= done_count_r + 16'd1;
        end
    end

    assign done_count = done_count_r;
`endif

    assign in_ready    = in_ready_r;
    assign mul_word0   = mul_word0_r;
    assign mul_word1   = mul_word1_r;
    assign mul_start   = mul_start_r;
    assign res_valid   = res_valid_r;
    assign res_product = res_product_r;

endmodule
